// File: rtl/accel_req_tracker.sv
// Elastic request FIFO toward Ara's accelerator port, with an outstanding-instruction cap,
// response accounting and sticky error/protocol status for end-of-test checks.
module accel_req_tracker #(
    parameter int ReqWidth       = 96,
    parameter int RespWidth      = 64,
    parameter int Depth          = 4,
    parameter int MaxOutstanding = 8,
    parameter bit HaltOnError    = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ReqWidth-1:0]  up_req_i,
    input  logic                 up_valid_i,
    output logic                 up_ready_o,
    output logic [ReqWidth-1:0]  acc_req_o,
    output logic                 acc_req_valid_o,
    input  logic                 acc_req_ready_i,
    input  logic [RespWidth-1:0] acc_resp_i,
    input  logic                 acc_resp_error_i,
    input  logic                 acc_resp_valid_i,
    output logic                 acc_resp_ready_o,
    output logic [15:0]          outstanding_o,
    output logic [31:0]          issued_cnt_o,
    output logic [31:0]          resp_cnt_o,
    output logic                 error_o,
    output logic [31:0]          err_idx_o,
    output logic                 proto_err_o,
    output logic                 idle_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = PtrW + 1;

    logic [ReqWidth-1:0] mem [Depth];
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]     count_q;
    logic [15:0]         outstanding_q;
    logic [31:0]         issued_q, resp_q, err_idx_q;
    logic                error_q, proto_q;

    logic full, empty, push, pop, resp_legal, resp_illegal, below_cap, halted;
    logic unused_resp;

    // Response payload is only observed by the environment, never stored here.
    assign unused_resp = ^acc_resp_i;

    assign full         = (count_q == CntW'(Depth));
    assign empty        = (count_q == '0);
    assign below_cap    = (outstanding_q < 16'(MaxOutstanding));
    assign halted       = HaltOnError && error_q;

    assign up_ready_o       = !full;
    assign acc_req_o        = mem[rd_ptr_q];
    assign acc_req_valid_o  = !empty && below_cap && !halted;
    assign acc_resp_ready_o = 1'b1;

    assign push         = up_valid_i && !full;
    assign pop          = acc_req_valid_o && acc_req_ready_i;
    assign resp_legal   = acc_resp_valid_i && (outstanding_q != '0);
    assign resp_illegal = acc_resp_valid_i && (outstanding_q == '0);

    // Payload storage carries no reset; only the pointers and counters decide what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= up_req_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            issued_q      <= '0;
            resp_q        <= '0;
            err_idx_q     <= '0;
            error_q       <= 1'b0;
            proto_q       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                issued_q <= issued_q + 32'd1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            case ({pop, resp_legal})
                2'b10:   outstanding_q <= outstanding_q + 16'd1;
                2'b01:   outstanding_q <= outstanding_q - 16'd1;
                default: outstanding_q <= outstanding_q;
            endcase
            if (resp_legal) begin
                resp_q <= resp_q + 32'd1;
                // Only the first error is recorded, indexed by the pre-increment response count.
                if (acc_resp_error_i && !error_q) begin
                    error_q   <= 1'b1;
                    err_idx_q <= resp_q;
                end
            end
            if (resp_illegal) begin
                proto_q <= 1'b1;
            end
        end
    end

    assign outstanding_o = outstanding_q;
    assign issued_cnt_o  = issued_q;
    assign resp_cnt_o    = resp_q;
    assign error_o       = error_q;
    assign err_idx_o     = err_idx_q;
    assign proto_err_o   = proto_q;
    assign idle_o        = empty && (outstanding_q == '0);

endmodule

// File: tb/tb_accel_req_tracker.sv
// Directed bench for accel_req_tracker: issued payloads are checked against a scoreboard
// queue, counters and status flags against values tracked step by step.
module tb_accel_req_tracker;

    localparam int ReqW = 96;
    localparam int RspW = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [ReqW-1:0] up_req;
    logic            up_valid;
    logic            up_ready;
    logic [ReqW-1:0] acc_req;
    logic            acc_req_valid;
    logic            acc_req_ready;
    logic [RspW-1:0] acc_resp;
    logic            acc_resp_error;
    logic            acc_resp_valid;
    logic            acc_resp_ready;
    logic [15:0]     outstanding;
    logic [31:0]     issued_cnt, resp_cnt, err_idx;
    logic            error_flag, proto_err, idle;

    int checks = 0;
    int errors = 0;
    logic [ReqW-1:0] sb[$];
    logic [ReqW-1:0] head;

    accel_req_tracker #(
        .ReqWidth(ReqW), .RespWidth(RspW), .Depth(4), .MaxOutstanding(2), .HaltOnError(1'b1)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .up_req_i(up_req), .up_valid_i(up_valid), .up_ready_o(up_ready),
        .acc_req_o(acc_req), .acc_req_valid_o(acc_req_valid), .acc_req_ready_i(acc_req_ready),
        .acc_resp_i(acc_resp), .acc_resp_error_i(acc_resp_error), .acc_resp_valid_i(acc_resp_valid),
        .acc_resp_ready_o(acc_resp_ready),
        .outstanding_o(outstanding), .issued_cnt_o(issued_cnt), .resp_cnt_o(resp_cnt),
        .error_o(error_flag), .err_idx_o(err_idx), .proto_err_o(proto_err), .idle_o(idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [ReqW-1:0] d);
        up_req   = d;
        up_valid = 1'b1;
        if (up_ready) sb.push_back(d);
        step();
        up_valid = 1'b0;
    endtask

    task automatic resp(input logic err);
        acc_resp_valid = 1'b1;
        acc_resp_error = err;
        acc_resp       = {$urandom, $urandom};
        step();
        acc_resp_valid = 1'b0;
        acc_resp_error = 1'b0;
    endtask

    function automatic logic [ReqW-1:0] rnd_req();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic chk_reset_state();
        chk("rst_up_ready", 64'(up_ready), 64'd1);
        chk("rst_valid", 64'(acc_req_valid), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_error", 64'(error_flag), 64'd0);
        chk("rst_proto", 64'(proto_err), 64'd0);
        chk("rst_outst", 64'(outstanding), 64'd0);
        chk("rst_issued", 64'(issued_cnt), 64'd0);
        chk("rst_resp", 64'(resp_cnt), 64'd0);
        chk("rst_err_idx", 64'(err_idx), 64'd0);
        chk("rst_resp_ready", 64'(acc_resp_ready), 64'd1);
    endtask

    // Every issue handshake must deliver the oldest accepted payload.
    always @(negedge clk) begin
        if (!rst && acc_req_valid && acc_req_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $error("FAIL sb_underflow observed=%0h expected=none", acc_req);
            end else begin
                logic [ReqW-1:0] exp_req;
                exp_req = sb.pop_front();
                assert (acc_req === exp_req) else begin
                    errors++;
                    $error("FAIL issue_payload observed=%0h expected=%0h", acc_req, exp_req);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; up_req = '0; up_valid = 1'b0; acc_req_ready = 1'b0;
        acc_resp = '0; acc_resp_error = 1'b0; acc_resp_valid = 1'b0;
        step(); step();
        rst = 1'b0;
        chk_reset_state();

        // Single request, accepted immediately, answered three cycles later.
        acc_req_ready = 1'b1;
        up_req = rnd_req(); up_valid = 1'b1; sb.push_back(up_req);
        chk("no_bypass", 64'(acc_req_valid), 64'd0);
        step();
        up_valid = 1'b0;
        chk("t1_valid", 64'(acc_req_valid), 64'd1);
        step();
        chk("t1_outst1", 64'(outstanding), 64'd1);
        chk("t1_issued", 64'(issued_cnt), 64'd1);
        step(); step();
        resp(1'b0);
        chk("t1_outst0", 64'(outstanding), 64'd0);
        chk("t1_resp", 64'(resp_cnt), 64'd1);
        chk("t1_idle", 64'(idle), 64'd1);

        // Fill the FIFO while Ara stalls; fifth push must be refused.
        acc_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) chk("full_up_ready", 64'(up_ready), 64'd0);
            push(rnd_req());
            if (i == 0) head = acc_req;
            chk("head_stable", 64'(acc_req[63:0]), 64'(head[63:0]));
        end
        chk("full_count", 64'(sb.size()), 64'd4);

        // Release: cap of 2 outstanding stops the third issue.
        acc_req_ready = 1'b1;
        step(); step(); step();
        chk("cap_issued", 64'(issued_cnt), 64'd3);
        chk("cap_outst", 64'(outstanding), 64'd2);
        chk("cap_valid", 64'(acc_req_valid), 64'd0);
        resp(1'b0);
        chk("cap_valid_again", 64'(acc_req_valid), 64'd1);
        step();
        chk("cap_third_issued", 64'(issued_cnt), 64'd4);
        chk("cap_outst2", 64'(outstanding), 64'd2);
        resp(1'b0);
        chk("pre_same_outst", 64'(outstanding), 64'd1);
        chk("pre_same_valid", 64'(acc_req_valid), 64'd1);
        resp(1'b0);
        chk("same_outst", 64'(outstanding), 64'd1);
        chk("same_issued", 64'(issued_cnt), 64'd5);
        chk("same_resp", 64'(resp_cnt), 64'd4);
        resp(1'b0);
        chk("drain_idle", 64'(idle), 64'd1);
        chk("drain_resp", 64'(resp_cnt), 64'd5);
        chk("drain_sb", 64'(sb.size()), 64'd0);

        // Response with nothing outstanding: protocol error, counts and error bit untouched.
        resp(1'b1);
        chk("proto_flag", 64'(proto_err), 64'd1);
        chk("proto_resp", 64'(resp_cnt), 64'd5);
        chk("proto_outst", 64'(outstanding), 64'd0);
        chk("proto_error", 64'(error_flag), 64'd0);

        // Reset in the middle of a burst.
        push(rnd_req()); push(rnd_req()); push(rnd_req());
        chk("burst_outst", 64'(outstanding), 64'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        chk_reset_state();

        // Third response errors: halt issuing, err_idx latched once.
        for (int i = 0; i < 4; i++) push(rnd_req());
        chk("err_pre_issued", 64'(issued_cnt), 64'd2);
        resp(1'b0);
        resp(1'b0);
        chk("err_pre_outst", 64'(outstanding), 64'd1);
        resp(1'b1);
        chk("err_flag", 64'(error_flag), 64'd1);
        chk("err_idx", 64'(err_idx), 64'd2);
        chk("err_issued", 64'(issued_cnt), 64'd4);
        chk("err_outst", 64'(outstanding), 64'd1);
        push(rnd_req());
        step();
        chk("halt_valid", 64'(acc_req_valid), 64'd0);
        chk("halt_issued", 64'(issued_cnt), 64'd4);
        chk("halt_idle", 64'(idle), 64'd0);
        resp(1'b1);
        chk("err2_idx", 64'(err_idx), 64'd2);
        chk("err2_resp", 64'(resp_cnt), 64'd4);
        chk("err2_outst", 64'(outstanding), 64'd0);
        chk("halt_pending", 64'(sb.size()), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
